// File: rtl/laser_alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : laser_alarm_pkg
// Purpose  : Shared state encoding, default timing constants and output decode
//            for the laser tripwire alarm controller.
// Revision : 1.0 - initial release
// ============================================================================
package laser_alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMING   = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } alarm_state_t;

  localparam int c_DEF_DEBOUNCE_CYCLES    = 50000;
  localparam int c_DEF_EXIT_DELAY_CYCLES  = 250000000;
  localparam int c_DEF_ENTRY_DELAY_CYCLES = 500000000;
  localparam int c_DEF_COUNT_W            = 8;

  // Moore decode, bit order {armed, pending, alarm}
  function automatic logic [2:0] state_outputs(input alarm_state_t s);
    case (s)
      ARMING:  return 3'b010;
      ARMED:   return 3'b100;
      ENTRY:   return 3'b110;
      ALARM:   return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/laser_alarm_if.sv
`default_nettype none
// ============================================================================
// Module   : laser_alarm_if
// Purpose  : Sensor/switch inputs and indicator/count outputs of the alarm.
// Revision : 1.0 - initial release
// ============================================================================
interface laser_alarm_if #(
  parameter int COUNT_W = 8
);
  logic               laser_triggered;
  logic               arm;
  logic               armed;
  logic               pending;
  logic               alarm;
  logic [COUNT_W-1:0] trip_count;

  modport master (
    output laser_triggered, arm,
    input  armed, pending, alarm, trip_count
  );

  modport slave (
    input  laser_triggered, arm,
    output armed, pending, alarm, trip_count
  );
endinterface
`default_nettype wire

// File: rtl/beam_debounce.sv
`default_nettype none
// ============================================================================
// Module   : beam_debounce
// Purpose  : Consecutive-cycle debouncer; o_level after DEBOUNCE_CYCLES high
//            samples, o_rise pulses on the edge where o_level goes high.
// Revision : 1.0 - initial release
// ============================================================================
module beam_debounce
  import laser_alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  i_in,
  output logic o_level,
  output logic o_rise
);

  localparam int              c_CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_MAX  = c_CW'(DEBOUNCE_CYCLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic [c_CW-1:0] r_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run <= '0;
    end else if (!i_in) begin
      r_run <= '0;
    end else if (r_run != c_MAX) begin
      r_run <= r_run + c_CW'(1);
    end
  end

  assign o_level = (r_run == c_MAX);
  // Asserted during the cycle whose closing edge saturates the run counter
  assign o_rise  = i_in && (r_run == c_LAST);

endmodule
`default_nettype wire

// File: rtl/laser_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module   : laser_alarm_controller
// Purpose  : Debounced tripwire input, arm/exit/entry/alarm FSM and
//            saturating beam-break counter.
// Revision : 1.0 - initial release
// ============================================================================
module laser_alarm_controller
  import laser_alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = c_DEF_DEBOUNCE_CYCLES,
  parameter int EXIT_DELAY_CYCLES  = c_DEF_EXIT_DELAY_CYCLES,
  parameter int ENTRY_DELAY_CYCLES = c_DEF_ENTRY_DELAY_CYCLES,
  parameter int COUNT_W            = c_DEF_COUNT_W
) (
  input  wire          clk,
  input  wire          reset,
  laser_alarm_if.slave bus
);

  localparam int            c_DLY_MAX    = (EXIT_DELAY_CYCLES > ENTRY_DELAY_CYCLES) ?
                                           EXIT_DELAY_CYCLES : ENTRY_DELAY_CYCLES;
  localparam int            c_DW         = (c_DLY_MAX > 1) ? $clog2(c_DLY_MAX) : 1;
  localparam logic [c_DW-1:0] c_EXIT_LOAD  = c_DW'(EXIT_DELAY_CYCLES - 1);
  localparam logic [c_DW-1:0] c_ENTRY_LOAD = c_DW'(ENTRY_DELAY_CYCLES - 1);

  alarm_state_t       r_state;
  logic [2:0]         r_out;
  logic [c_DW-1:0]    r_dly;
  logic [COUNT_W-1:0] r_count;
  logic               r_trig_q;
  logic               w_level;
  logic               w_rise;
  logic               w_break_evt;
  logic [COUNT_W-1:0] w_count_sat;

  always_ff @(posedge clk) begin
    if (reset) r_trig_q <= 1'b0;
    else       r_trig_q <= bus.laser_triggered;
  end

  beam_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .i_in    (r_trig_q),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_break_evt = w_rise & ~w_level;
  assign w_count_sat = (r_count == {COUNT_W{1'b1}}) ? r_count : r_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DISARMED;
      r_out   <= 3'b000;
      r_dly   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        DISARMED: begin
          if (bus.arm) begin
            r_state <= ARMING;
            r_out   <= state_outputs(ARMING);
            r_dly   <= c_EXIT_LOAD;
            r_count <= '0;
          end
        end
        ARMING: begin
          if (!bus.arm) begin
            r_state <= DISARMED;
            r_out   <= state_outputs(DISARMED);
          end else if (r_dly == '0) begin
            r_state <= ARMED;
            r_out   <= state_outputs(ARMED);
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        ARMED: begin
          if (!bus.arm) begin
            r_state <= DISARMED;
            r_out   <= state_outputs(DISARMED);
          end else if (w_break_evt) begin
            r_state <= ENTRY;
            r_out   <= state_outputs(ENTRY);
            r_dly   <= c_ENTRY_LOAD;
            r_count <= w_count_sat;
          end
        end
        ENTRY: begin
          if (!bus.arm) begin
            r_state <= DISARMED;
            r_out   <= state_outputs(DISARMED);
          end else begin
            if (w_break_evt) r_count <= w_count_sat;
            if (r_dly == '0) begin
              r_state <= ALARM;
              r_out   <= state_outputs(ALARM);
            end else begin
              r_dly <= r_dly - 1'b1;
            end
          end
        end
        ALARM: begin
          if (!bus.arm) begin
            r_state <= DISARMED;
            r_out   <= state_outputs(DISARMED);
          end else if (w_break_evt) begin
            r_count <= w_count_sat;
          end
        end
        default: begin
          r_state <= DISARMED;
          r_out   <= state_outputs(DISARMED);
        end
      endcase
    end
  end

  assign bus.armed      = r_out[2];
  assign bus.pending    = r_out[1];
  assign bus.alarm      = r_out[0];
  assign bus.trip_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_laser_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_laser_alarm_controller
// Purpose  : Directed scoreboard bench for laser_alarm_controller
//            (DEBOUNCE=4, EXIT=8, ENTRY=10, COUNT_W=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_laser_alarm_controller;

  localparam int c_DEB   = 4;
  localparam int c_EXIT  = 8;
  localparam int c_ENTRY = 10;
  localparam int c_CW    = 3;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  laser_alarm_if #(.COUNT_W(c_CW)) bus ();

  laser_alarm_controller #(
    .DEBOUNCE_CYCLES    (c_DEB),
    .EXIT_DELAY_CYCLES  (c_EXIT),
    .ENTRY_DELAY_CYCLES (c_ENTRY),
    .COUNT_W            (c_CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Push the expectation, advance n cycles, then pop and compare
  task automatic step(input string tag, input int n, input logic a, input logic p,
                      input logic al, input int c);
    exp_t e;
    exp_t got;
    logic [5:0] obs;
    e.tag = tag;
    e.exp = {a, p, al, 3'(c)};
    sb.push_back(e);
    tick(n);
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty at %s", tag);
    end else begin
      got = sb.pop_front();
      obs = {bus.armed, bus.pending, bus.alarm, bus.trip_count};
      assert (obs === got.exp) else begin
        n_fail++;
        $error("FAIL %s: observed {armed,pending,alarm,count}=%b_%0d required %b_%0d",
               got.tag, obs[5:3], obs[2:0], got.exp[5:3], got.exp[2:0]);
      end
    end
  endtask

  initial begin
    int exp_cnt;
    reset = 1'b1;
    bus.laser_triggered = 1'b0;
    bus.arm = 1'b0;
    step("reset", 3, 0, 0, 0, 0);
    reset = 1'b0;
    step("idle", 2, 0, 0, 0, 0);

    // Exit delay
    bus.arm = 1'b1;
    for (int i = 0; i < 8; i++) step("arming", 1, 0, 1, 0, 0);
    step("armed", 1, 1, 0, 0, 0);

    // Glitch shorter than the debounce window
    bus.laser_triggered = 1'b1;
    tick(3);
    bus.laser_triggered = 1'b0;
    for (int i = 0; i < 6; i++) step("short_pulse", 1, 1, 0, 0, 0);

    // Real break: ENTRY five edges after the rise
    bus.laser_triggered = 1'b1;
    step("debounce_wait", 4, 1, 0, 0, 0);
    step("entry", 1, 1, 1, 0, 1);
    step("entry_hold", 1, 1, 1, 0, 1);
    bus.laser_triggered = 1'b0;
    for (int i = 0; i < 8; i++) step("entry_dwell", 1, 1, 1, 0, 1);
    step("alarm", 1, 1, 0, 1, 1);
    for (int i = 0; i < 100; i++) step("alarm_latched", 1, 1, 0, 1, 1);
    bus.arm = 1'b0;
    step("disarm", 1, 0, 0, 0, 1);
    step("disarm_hold", 3, 0, 0, 0, 1);

    // Disarm part-way through ENTRY
    bus.arm = 1'b1;
    step("rearm_clears", 1, 0, 1, 0, 0);
    tick(7);
    step("armed2", 1, 1, 0, 0, 0);
    bus.laser_triggered = 1'b1;
    step("entry2", 5, 1, 1, 0, 1);
    bus.laser_triggered = 1'b0;
    tick(4);
    bus.arm = 1'b0;
    step("entry_abort", 1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step("no_alarm", 1, 0, 0, 0, 1);

    // Counter saturation while in ALARM
    bus.arm = 1'b1;
    step("armed3", 9, 1, 0, 0, 0);
    bus.laser_triggered = 1'b1;
    step("entry3", 5, 1, 1, 0, 1);
    tick(1);
    bus.laser_triggered = 1'b0;
    tick(2);
    step("alarm3", 10, 1, 0, 1, 1);
    exp_cnt = 1;
    for (int k = 0; k < 9; k++) begin
      exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
      bus.laser_triggered = 1'b1;
      step("saturate", 5, 1, 0, 1, exp_cnt);
      tick(1);
      bus.laser_triggered = 1'b0;
      tick(2);
    end
    bus.arm = 1'b0;
    step("disarm_keeps_count", 1, 0, 0, 0, 7);

    // Reset mid-ENTRY, then a break during ARMING
    bus.arm = 1'b1;
    step("armed4", 9, 1, 0, 0, 0);
    bus.laser_triggered = 1'b1;
    step("entry4", 5, 1, 1, 0, 1);
    bus.laser_triggered = 1'b0;
    tick(3);
    reset = 1'b1;
    step("reset_mid_entry", 1, 0, 0, 0, 0);
    reset = 1'b0;
    step("arming_after_reset", 1, 0, 1, 0, 0);
    for (int i = 2; i <= 8; i++) begin
      bus.laser_triggered = (i <= 7);
      step("arming_break_ignored", 1, 0, 1, 0, 0);
    end
    bus.laser_triggered = 1'b0;
    step("armed_after_break", 1, 1, 0, 0, 0);
    step("armed_no_count", 3, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/laser_alarm_controller.md
Name: laser_alarm_controller

Overview:
Downstream consumer of the laser tripwire detector's laser_triggered flag. Filters the flag with a consecutive-cycle debouncer and runs the arm/exit-delay/entry-delay/alarm state machine. Also keeps a saturating count of beam-break events. Drives LED/buzzer outputs and feeds the trip count to the display logic.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive sampled-high cycles before a break is accepted (1 ms at 50 MHz); legal range 1 or more
EXIT_DELAY_CYCLES, 250000000, cycles spent in ARMING after arm goes high (5 s); legal range 1 or more
ENTRY_DELAY_CYCLES, 500000000, cycles spent in ENTRY before alarm latches (10 s); legal range 1 or more
COUNT_W, 8, width of trip_count

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
laser_triggered  input  1  beam-broken flag from the tripwire detector; may glitch, asynchronous to state of this block
arm  input  1  level switch; 1 = armed request, 0 = disarm
armed  output  1  1 in ARMED, ENTRY, ALARM
pending  output  1  1 in ARMING or ENTRY (blink/beep driver)
alarm  output  1  1 in ALARM only
trip_count  output  COUNT_W  number of accepted beam breaks since last arming

Behaviour:
- Reset: state = DISARMED; armed/pending/alarm = 0; trip_count = 0; debounce and delay counters = 0. Reset has priority over all other inputs, including mid-delay and mid-alarm.
- Input stage: laser_triggered is registered once (trig_q).
- Debounce: run counter increments while trig_q=1 and clears to 0 on the first cycle trig_q=0.
  - beam_broken = 1 while run counter has reached DEBOUNCE_CYCLES; the counter saturates there.
  - break_evt = single-cycle pulse on the rising edge of beam_broken.
  - A continuous break produces exactly one break_evt. A pulse shorter than DEBOUNCE_CYCLES produces none.
- All outputs are Moore-decoded from the registered state. trip_count is a register.
- States and transitions, evaluated each clock edge, in priority order:
  - DISARMED: arm=1 -> ARMING; load delay counter with EXIT_DELAY_CYCLES-1; clear trip_count.
  - ARMING: arm=0 -> DISARMED. If delay counter = 0 -> ARMED, else decrement. break_evt is ignored and not counted.
  - ARMED: arm=0 -> DISARMED. break_evt -> ENTRY; load ENTRY_DELAY_CYCLES-1.
  - ENTRY: arm=0 -> DISARMED. If delay counter = 0 -> ALARM, else decrement.
  - ALARM: latched; exits only on arm=0 -> DISARMED.
  - Illegal or unused encoding -> DISARMED.
- Dwell times: ARMING lasts exactly EXIT_DELAY_CYCLES cycles; ENTRY lasts exactly ENTRY_DELAY_CYCLES cycles.
- trip_count increments by 1 on each break_evt while in ARMED, ENTRY or ALARM. It saturates at 2^COUNT_W-1 and does not wrap. It holds its value in DISARMED so it can be read after disarm.
- Simultaneous events:
  - arm=0 coincident with break_evt or delay expiry: disarm wins and the count is not incremented.
  - break_evt on the same edge as ARMING->ARMED: ignored.
- Latency:
  - Rising edge of laser_triggered to break_evt is DEBOUNCE_CYCLES+1 edges.
  - The state update and trip_count increment occur on that same edge.
  - Outputs change with the state register, with no extra cycle.

Decomposition:
- Package laser_alarm_pkg holds:
  - state enum alarm_state_t {DISARMED, ARMING, ARMED, ENTRY, ALARM}
  - default constants for the debounce and delay cycle counts
- One natural sub-module: beam_debounce (clk, reset, in, level out, rise-pulse out), parameterised by DEBOUNCE_CYCLES.
- The delay counter width is derived with $clog2 of the larger of EXIT_DELAY_CYCLES and ENTRY_DELAY_CYCLES.

Test Plan:
All scenarios use bench parameters DEBOUNCE=4, EXIT=8, ENTRY=10, COUNT_W=3.
- Reset then arm=1 at cycle 0 -> pending=1 for exactly 8 cycles; then armed=1, pending=0, alarm=0, trip_count=0.
- In ARMED, laser_triggered high for 3 cycles, then low -> no state change, trip_count=0. Then high for 6 cycles -> ENTRY entered 5 edges after the rise, trip_count=1, pending=1.
- Stay in ENTRY with arm held -> alarm=1 exactly 10 cycles after entering ENTRY. alarm stays 1 for 100 further cycles. Drop arm -> next edge all outputs 0, trip_count still 1.
- In ENTRY, drop arm at cycle 5 -> DISARMED, alarm never asserts.
- In ALARM, apply 9 separate 6-cycle breaks -> trip_count stops at 7 (saturates).
- Reset asserted mid-ENTRY, and a break during ARMING -> reset returns all outputs and trip_count to 0 immediately. The ARMING break is not counted, and ARMED is still reached after 8 cycles.
